// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I-cache / D-cache arbiter for one shared line-memory port (optional MEM_ARB_ROUND_ROBIN_EN)
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state_q;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [ADDR_W-1:0] pmem_address_q;
    logic [LINE_W-1:0] pmem_wdata_q;
    logic              d_req;
    logic              grant_d;

    assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // High when the most recent grant went to the D-cache.
    logic last_d_q;
    assign grant_d = d_req & (~i_read | ~last_d_q);
`else
    // Fixed priority: the D-cache always wins so the MEM-stage stall clears first.
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q        <= SERVE_D;
                        pmem_address_q <= d_addr;
                        pmem_wdata_q   <= d_wdata;
                        pmem_write_q   <= d_write;
                        pmem_read_q    <= d_read & ~d_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d_q       <= 1'b1;
`endif
                    end else if (i_read) begin
                        state_q        <= SERVE_I;
                        pmem_address_q <= i_addr;
                        pmem_read_q    <= 1'b1;
                        pmem_write_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d_q       <= 1'b0;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_q      <= IDLE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Completion is routed only to the owner of the in-flight transaction.
    assign i_resp       = (state_q == SERVE_I) & pmem_resp;
    assign d_resp       = (state_q == SERVE_D) & pmem_resp;
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign arb_busy     = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one physical-memory port between the instruction-cache (read-only) and data-cache (read/write) miss paths of the pipelined LC-3b core. Sits between both caches and the unified next-level memory. Accepts at most one outstanding line transaction, latches the winner's address and write data, and drives the shared port until `pmem_resp`. It then returns the line, or the write acknowledge, to the winner only.

## Interface
- `ADDR_W`, 16, line address width in bits
- `LINE_W`, 128, cache line width in bits
- `clk`  in  1  clock, all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `i_read`  in  1  I-cache line read request, held until `i_resp`
- `i_addr`  in  ADDR_W  I-cache line address
- `i_resp`  out  1  I-cache completion, one-cycle pulse
- `i_rdata`  out  LINE_W  line data to I-cache, valid when `i_resp`
- `d_read`  in  1  D-cache line read request, held until `d_resp`
- `d_write`  in  1  D-cache line write (writeback) request, held until `d_resp`
- `d_addr`  in  ADDR_W  D-cache line address
- `d_wdata`  in  LINE_W  D-cache writeback line
- `d_resp`  out  1  D-cache completion, one-cycle pulse
- `d_rdata`  out  LINE_W  line data to D-cache, valid when `d_resp`
- `pmem_read`  out  1  shared-port read strobe, registered
- `pmem_write`  out  1  shared-port write strobe, registered
- `pmem_address`  out  ADDR_W  shared-port address, registered
- `pmem_wdata`  out  LINE_W  shared-port write data, registered
- `pmem_rdata`  in  LINE_W  shared-port read data, valid with `pmem_resp`
- `pmem_resp`  in  1  shared-port completion, one cycle
- `arb_busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D.
- **IDLE**
  - Only `i_read`: go to SERVE_I. Latch `pmem_address <= i_addr`, `pmem_read <= 1`.
  - Only `d_read|d_write`: go to SERVE_D. Latch `d_addr` and `d_wdata`. Set `pmem_write <= d_write` and `pmem_read <= d_read & ~d_write`.
  - Both requesting (tie): resolved per Configuration.
  - No request: stay in IDLE.
- **SERVE_I / SERVE_D**
  - Hold the latched strobes, address and wdata constant; the requester's inputs are ignored after grant.
  - On `pmem_resp`: assert the winner's `*_resp` combinationally in the same cycle, clear both strobes, go to IDLE.
- `d_read & d_write` together is illegal; write wins.
- `i_rdata` and `d_rdata` are continuous copies of `pmem_rdata`. Consumers qualify them with their own resp.
- A `pmem_resp` arriving in IDLE is ignored; no resp is pulsed.
- Reset (async, any state): state to IDLE. `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `i_resp`, `d_resp`, `arb_busy` all 0; last-grant register = I. An in-flight transaction is abandoned and no resp is issued.

## Timing
- Request seen in IDLE at cycle N: strobes and address valid at the port from cycle N+1.
- `pmem_resp` in cycle M: `*_resp` high in M only; strobes low from M+1; state IDLE in M+1.
- Minimum request-to-resp latency is 2 cycles, reached when `pmem_resp` arrives in N+1.
- Back-to-back transactions always have exactly one IDLE cycle between them. A request present in M+1 is granted in M+1, and its strobes appear in M+2.
- Never more than one strobe high; never both resps high.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - A tie grants the requester not served last.
  - The last-grant register updates on every grant; its reset value is I, so the first tie goes to D.
  - No requester waits more than one other transaction.
- `MEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: a tie always goes to D, so the MEM-stage stall clears first.
  - The last-grant register is not implemented.

## Test plan
- I-only: `i_read=1`, `i_addr=16'h1230`, `pmem_resp` 3 cycles after strobe, `pmem_rdata=128'hA5…` -> `pmem_read=1`, `pmem_address=16'h1230` from N+1; `i_resp` pulses one cycle with `i_rdata=128'hA5…`; `d_resp` stays 0.
- D write: `d_write=1`, `d_addr=16'h4440`, `d_wdata=128'h55…` -> `pmem_write=1` with those values held until `pmem_resp`; then `d_resp` pulses; `pmem_read` never asserts.
- Tie, round-robin defined: `i_read` and `d_read` held from reset -> order is D, I, D, with one IDLE cycle between each. Undefined: D wins every tie, and I is served only once `d_read` drops.
- Input change after grant: change `d_addr` 16'h0100 -> 16'h0200 while in SERVE_D -> `pmem_address` stays 16'h0100.
- Async reset mid-SERVE_I with `pmem_read=1` -> all outputs 0 immediately; a later `pmem_resp` produces no `i_resp`.
- Illegal `d_read=d_write=1` -> `pmem_write=1`, `pmem_read=0`.
